// File: rtl/ltssm_pkg.sv
// Shared LTSSM encodings used by the substate sequencer and the master TX/RX substate checkers.
package ltssm_pkg;

  localparam int MAXLANES = 16;
  typedef logic [MAXLANES-1:0] lane_mask_t;

  localparam logic [4:0] SS_DETECT_QUIET        = 5'd0;
  localparam logic [4:0] SS_DETECT_ACTIVE       = 5'd1;
  localparam logic [4:0] SS_POLLING_ACTIVE      = 5'd2;
  localparam logic [4:0] SS_POLLING_COMPLIANCE  = 5'd3;
  localparam logic [4:0] SS_POLLING_CONFIG      = 5'd4;
  localparam logic [4:0] SS_CONFIG_LW_START     = 5'd5;
  localparam logic [4:0] SS_CONFIG_LW_ACCEPT    = 5'd6;
  localparam logic [4:0] SS_CONFIG_LN_WAIT      = 5'd7;
  localparam logic [4:0] SS_CONFIG_LN_ACCEPT    = 5'd8;
  localparam logic [4:0] SS_CONFIG_COMPLETE     = 5'd9;
  localparam logic [4:0] SS_L0                  = 5'd10;
  localparam logic [4:0] SS_RECOVERY_RCVR_LOCK  = 5'd11;
  localparam logic [4:0] SS_RECOVERY_RCVR_CFG   = 5'd12;
  localparam logic [4:0] SS_RECOVERY_SPEED      = 5'd13;
  localparam logic [4:0] SS_RECOVERY_EQ_PHASE0  = 5'd14;
  localparam logic [4:0] SS_RECOVERY_EQ_PHASE1  = 5'd15;
  localparam logic [4:0] SS_RECOVERY_EQ_PHASE2  = 5'd16;
  localparam logic [4:0] SS_RECOVERY_EQ_PHASE3  = 5'd17;
  localparam logic [4:0] SS_RECOVERY_IDLE       = 5'd18;

  localparam logic [3:0] LPIF_IDLE     = 4'd0;
  localparam logic [3:0] LPIF_TRAINING = 4'd1;
  localparam logic [3:0] LPIF_LINK_UP  = 4'd2;
  localparam logic [3:0] LPIF_RECOVERY = 4'd3;

  typedef enum logic [2:0] {
    TMR_NONE, TMR_1MS, TMR_2MS, TMR_12MS, TMR_24MS, TMR_48MS
  } timer_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESOLVE, ST_LINKUP
  } ctl_state_e;

  function automatic logic [4:0] sanitize_exit(input logic [4:0] exit_to);
    return (exit_to > SS_RECOVERY_IDLE) ? SS_DETECT_QUIET : exit_to;
  endfunction

  function automatic logic [3:0] lpif_code(input ctl_state_e st, input logic [4:0] ss);
    if (st == ST_IDLE) return LPIF_IDLE;
    if (st == ST_LINKUP) return LPIF_LINK_UP;
    if (ss >= SS_RECOVERY_RCVR_LOCK && ss <= SS_RECOVERY_IDLE) return LPIF_RECOVERY;
    return LPIF_TRAINING;
  endfunction

endpackage

// File: rtl/ltssm_watchdog.sv
// Stall watchdog: load arms a down-counter, run decrements it, expire flags terminal count while running.
module ltssm_watchdog #(
  parameter int WDOG_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [WDOG_W-1:0] load_value,
  input  logic              run,
  output logic              expire
);

  logic [WDOG_W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (run && count != '0) begin
      count <= count - WDOG_W'(1);
    end
  end

  assign expire = run && (count == '0);

endmodule

// File: rtl/ltssm_substate_sequencer.sv
// LTSSM substate sequencer: requests substates from the TX/RX checkers and merges their exits.
//
// state   | meaning
// IDLE    | link disabled, parked in detectQuiet
// ISSUE   | one-cycle request of substate to both checkers
// WAIT    | collecting TX/RX finishes under the watchdog
// RESOLVE | merging the latched exits into the next substate
// LINKUP  | holding L0 until a retrain request
module ltssm_substate_sequencer
  import ltssm_pkg::*;
#(
  parameter int                WDOG_W     = 24,
  parameter logic [WDOG_W-1:0] WDOG_LIMIT = 24'd12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       linkEnable,
  input  logic       retrainReq,
  input  logic       txFinish,
  input  logic       rxFinish,
  input  logic [4:0] txExitTo,
  input  logic [4:0] rxExitTo,
  output logic [4:0] substate,
  output logic       substateReq,
  output logic       linkUp,
  output logic [3:0] lpifStatus,
  output logic [7:0] failCount,
  output logic       exitMismatch
);

  ctl_state_e state_q, state_d;
  logic [4:0] substate_d, resolved;
  logic [4:0] tx_exit_q, tx_exit_d, rx_exit_q, rx_exit_d;
  logic       tx_done_q, tx_done_d, rx_done_q, rx_done_d;
  logic [7:0] fail_d;
  logic       mismatch_d, both_done;
  logic       wd_clear, wd_load, wd_expire;

  ltssm_watchdog #(.WDOG_W(WDOG_W)) u_watchdog (
    .clk        (clk),
    .reset      (reset),
    .clear      (wd_clear),
    .load       (wd_load),
    .load_value (WDOG_LIMIT - WDOG_W'(1)),
    .run        (state_q == ST_WAIT),
    .expire     (wd_expire)
  );

  always_comb begin
    state_d    = state_q;
    substate_d = substate;
    tx_done_d  = tx_done_q;
    rx_done_d  = rx_done_q;
    tx_exit_d  = tx_exit_q;
    rx_exit_d  = rx_exit_q;
    fail_d     = failCount;
    mismatch_d = exitMismatch;
    wd_clear   = 1'b0;
    wd_load    = 1'b0;
    resolved   = SS_DETECT_QUIET;
    both_done  = (tx_done_q | txFinish) & (rx_done_q | rxFinish);
    case (state_q)
      ST_IDLE: begin
        substate_d = SS_DETECT_QUIET;
        wd_clear   = 1'b1;
        if (linkEnable) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        tx_done_d = 1'b0;
        rx_done_d = 1'b0;
        wd_load   = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (txFinish && !tx_done_q) begin
          tx_done_d = 1'b1;
          tx_exit_d = sanitize_exit(txExitTo);
        end
        if (rxFinish && !rx_done_q) begin
          rx_done_d = 1'b1;
          rx_exit_d = sanitize_exit(rxExitTo);
        end
        // A finish completing the pair outranks a simultaneous watchdog expiry.
        if (both_done) begin
          state_d = ST_RESOLVE;
        end else if (wd_expire) begin
          state_d    = ST_ISSUE;
          substate_d = SS_DETECT_QUIET;
          fail_d     = (failCount == 8'hFF) ? 8'hFF : failCount + 8'd1;
        end
      end
      ST_RESOLVE: begin
        if (tx_exit_q == SS_DETECT_QUIET || rx_exit_q == SS_DETECT_QUIET) begin
          resolved = SS_DETECT_QUIET;
          if (substate != SS_DETECT_QUIET && substate != SS_DETECT_ACTIVE)
            fail_d = (failCount == 8'hFF) ? 8'hFF : failCount + 8'd1;
        end else if (tx_exit_q == rx_exit_q) begin
          resolved = rx_exit_q;
        end else begin
          resolved   = rx_exit_q;
          mismatch_d = 1'b1;
        end
        substate_d = resolved;
        state_d    = (resolved == SS_L0) ? ST_LINKUP : ST_ISSUE;
      end
      ST_LINKUP: begin
        substate_d = SS_L0;
        if (retrainReq) begin
          substate_d = SS_RECOVERY_RCVR_LOCK;
          state_d    = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!linkEnable) begin
      state_d    = ST_IDLE;
      substate_d = SS_DETECT_QUIET;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      substate     <= SS_DETECT_QUIET;
      substateReq  <= 1'b0;
      linkUp       <= 1'b0;
      lpifStatus   <= LPIF_IDLE;
      failCount    <= 8'd0;
      exitMismatch <= 1'b0;
      tx_done_q    <= 1'b0;
      rx_done_q    <= 1'b0;
      tx_exit_q    <= SS_DETECT_QUIET;
      rx_exit_q    <= SS_DETECT_QUIET;
    end else begin
      state_q      <= state_d;
      substate     <= substate_d;
      substateReq  <= (state_d == ST_ISSUE) || (state_d == ST_LINKUP && state_q != ST_LINKUP);
      linkUp       <= (state_d == ST_LINKUP);
      lpifStatus   <= lpif_code(state_d, substate_d);
      failCount    <= fail_d;
      exitMismatch <= mismatch_d;
      tx_done_q    <= tx_done_d;
      rx_done_q    <= rx_done_d;
      tx_exit_q    <= tx_exit_d;
      rx_exit_q    <= rx_exit_d;
    end
  end

endmodule

// File: tb/tb_ltssm_substate_sequencer.sv
// Scoreboard bench for the LTSSM substate sequencer: each request pulse is checked against a queued expectation.
module tb_ltssm_substate_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       linkEnable = 1'b0;
  logic       retrainReq = 1'b0;
  logic       txFinish = 1'b0;
  logic       rxFinish = 1'b0;
  logic [4:0] txExitTo = 5'd0;
  logic [4:0] rxExitTo = 5'd0;
  logic [4:0] substate;
  logic       substateReq;
  logic       linkUp;
  logic [3:0] lpifStatus;
  logic [7:0] failCount;
  logic       exitMismatch;

  typedef struct {
    int ss;
    int fc;
    int mm;
    int lpif;
    int lu;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  ltssm_substate_sequencer #(.WDOG_W(24), .WDOG_LIMIT(24'd100)) dut (
    .clk          (clk),
    .reset        (reset),
    .linkEnable   (linkEnable),
    .retrainReq   (retrainReq),
    .txFinish     (txFinish),
    .rxFinish     (rxFinish),
    .txExitTo     (txExitTo),
    .rxExitTo     (rxExitTo),
    .substate     (substate),
    .substateReq  (substateReq),
    .linkUp       (linkUp),
    .lpifStatus   (lpifStatus),
    .failCount    (failCount),
    .exitMismatch (exitMismatch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int ss, input int fc, input int mm, input int lpif, input int lu, input int c);
    exp_t e;
    e.ss = ss; e.fc = fc; e.mm = mm; e.lpif = lpif; e.lu = lu; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every request pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (substateReq === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_req: actual=request for substate %0d at cycle %0d required=no request", substate, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("req_substate", int'(substate), mon_e.ss);
        chk("req_cycle", cyc, mon_e.cyc);
        chk("req_failcount", int'(failCount), mon_e.fc);
        chk("req_mismatch", int'(exitMismatch), mon_e.mm);
        chk("req_lpif", int'(lpifStatus), mon_e.lpif);
        chk("req_linkup", int'(linkUp), mon_e.lu);
      end
    end
  end

  task automatic wait_req(output int rc);
    int n = 0;
    while (substateReq !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (substateReq !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL req_timeout: actual=no substateReq after %0d cycles required=one request", n);
    end
    rc = cyc;
  endtask

  // Checker model: answer the pending request 5 cycles later with both finishes.
  task automatic step(input int txe, input int rxe, input int ss, input int fc,
                      input int mm, input int lpif, input int lu);
    int r;
    wait_req(r);
    while (cyc < r + 5) @(negedge clk);
    txExitTo = 5'(txe);
    rxExitTo = 5'(rxe);
    txFinish = 1'b1;
    rxFinish = 1'b1;
    push(ss, fc, mm, lpif, lu, cyc + 2);
    @(negedge clk);
    txFinish = 1'b0;
    rxFinish = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=still running required=finished");
    $fatal(1);
  end

  initial begin
    int r;
    repeat (3) @(negedge clk);
    chk("rst_substate", int'(substate), 0);
    chk("rst_req", int'(substateReq), 0);
    chk("rst_linkup", int'(linkUp), 0);
    chk("rst_lpif", int'(lpifStatus), 0);
    chk("rst_failcount", int'(failCount), 0);
    chk("rst_mismatch", int'(exitMismatch), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Normal training 0 -> 10
    linkEnable = 1'b1;
    push(0, 0, 0, 1, 0, cyc + 1);
    for (int k = 1; k <= 10; k++)
      step(k, k, k, 0, 0, (k == 10) ? 2 : 1, (k == 10) ? 1 : 0);
    wait_req(r);
    repeat (2) @(negedge clk);
    chk("l0_linkup", int'(linkUp), 1);
    chk("l0_lpif", int'(lpifStatus), 2);

    // Retrain from L0
    retrainReq = 1'b1;
    push(11, 0, 0, 3, 0, cyc + 1);
    @(negedge clk);
    retrainReq = 1'b0;
    chk("retrain_linkup", int'(linkUp), 0);
    step(2, 2, 2, 0, 0, 1, 0);
    step(3, 3, 3, 0, 0, 1, 0);

    // Failure path: RX proposes detectQuiet from substate 3
    step(4, 0, 0, 1, 0, 1, 0);
    step(1, 1, 1, 1, 0, 1, 0);
    step(2, 2, 2, 1, 0, 1, 0);
    step(3, 3, 3, 1, 0, 1, 0);
    step(4, 4, 4, 1, 0, 1, 0);

    // Skewed finishes in substate 4
    wait_req(r);
    while (cyc < r + 3) @(negedge clk);
    rxExitTo = 5'd5;
    rxFinish = 1'b1;
    @(negedge clk);
    rxFinish = 1'b0;
    while (cyc < r + 40) @(negedge clk);
    chk("skew_hold_substate", int'(substate), 4);
    txExitTo = 5'd5;
    txFinish = 1'b1;
    push(5, 1, 0, 1, 0, cyc + 2);
    @(negedge clk);
    txFinish = 1'b0;

    // Mismatch: TX 7, RX 6 from substate 5
    step(7, 6, 6, 1, 1, 1, 0);

    // Watchdog: only RX answers in substate 6
    wait_req(r);
    while (cyc < r + 3) @(negedge clk);
    rxExitTo = 5'd7;
    rxFinish = 1'b1;
    push(0, 2, 1, 1, 0, r + 101);
    @(negedge clk);
    rxFinish = 1'b0;

    // Out-of-range exits from detectQuiet: no failure counted
    step(25, 25, 0, 2, 1, 1, 0);
    step(1, 1, 1, 2, 1, 1, 0);

    // Abort mid-WAIT
    wait_req(r);
    while (cyc < r + 3) @(negedge clk);
    linkEnable = 1'b0;
    @(negedge clk);
    chk("abort_substate", int'(substate), 0);
    chk("abort_lpif_idle", int'(lpifStatus), 0);
    chk("abort_linkup", int'(linkUp), 0);
    chk("abort_failcount", int'(failCount), 2);
    repeat (5) @(negedge clk);
    linkEnable = 1'b1;
    push(0, 2, 1, 1, 0, cyc + 1);
    step(1, 1, 1, 2, 1, 1, 0);

    // Reset mid-WAIT
    wait_req(r);
    while (cyc < r + 3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_substate", int'(substate), 0);
    chk("mid_rst_req", int'(substateReq), 0);
    chk("mid_rst_linkup", int'(linkUp), 0);
    chk("mid_rst_lpif", int'(lpifStatus), 0);
    chk("mid_rst_failcount", int'(failCount), 0);
    chk("mid_rst_mismatch", int'(exitMismatch), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    push(0, 0, 0, 1, 0, cyc + 1);
    wait_req(r);
    linkEnable = 1'b0;
    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ltssm_substate_sequencer.md
# ltssm_substate_sequencer

Top-level LTSSM sequencer for the Gen3 PHY link-training path. It owns the current LTSSM substate and issues it as a request to the master TX and master RX substate checkers. It waits for both checkers to report completion, resolves their exit substates into the next substate, and holds the link in L0 until a retrain is requested. A watchdog forces Detect.Quiet if either checker stalls.

## Interface
- MAXLANES, 16: lanes supported; sizes `laneMask`.
- WDOG_W, 24: watchdog counter width.
- WDOG_LIMIT, 24'd12500000: cycles allowed in WAIT before a forced return to Detect (100 ms at 125 MHz).

- clk  in  1  single clock, all logic rising-edge
- reset  in  1  asynchronous, active-low
- linkEnable  in  1  level; 1 = train the link, 0 = hold in Detect.Quiet
- retrainReq  in  1  pulse; honoured only in L0, requests Recovery
- txFinish  in  1  pulse from master TX checker: current substate done
- rxFinish  in  1  pulse from master RX checker: current substate done
- txExitTo  in  5  TX-proposed next substate, valid with txFinish
- rxExitTo  in  5  RX-proposed next substate, valid with rxFinish
- substate  out  5  current substate driven to both checkers
- substateReq  out  1  one-cycle pulse: new request on `substate`
- linkUp  out  1  1 while in L0
- lpifStatus  out  4  0 reset/idle, 1 training, 2 link up, 3 recovery
- failCount  out  8  saturating count of forced/failed returns to Detect.Quiet
- exitMismatch  out  1  sticky; set when TX and RX exit proposals differ

## Operation
- Control FSM states: IDLE, ISSUE, WAIT, RESOLVE, LINKUP.
- IDLE:
  - substate = detectQuiet.
  - linkEnable=1 -> ISSUE.
- ISSUE:
  - substateReq=1 for exactly one cycle.
  - Clears the txDone/rxDone flags and the watchdog.
  - Next state: WAIT.
- WAIT:
  - txFinish sets txDone; rxFinish sets rxDone. The flags are sticky, so the two finishes may arrive in any order or in the same cycle.
  - The latched exit value is captured with each flag.
  - Both flags set -> RESOLVE.
  - Watchdog reaches WDOG_LIMIT -> next substate = detectQuiet, failCount++, -> ISSUE.
- RESOLVE: next substate is chosen by priority:
  1. Either exit is detectQuiet -> detectQuiet; failCount++ unless the current substate is detectQuiet or detectActive.
  2. Exits equal -> that value.
  3. Exits differ -> rxExitTo, and exitMismatch is set.
  - Next is L0 -> LINKUP; otherwise -> ISSUE.
- LINKUP:
  - linkUp=1, substate=L0; one substateReq pulse on entry.
  - retrainReq -> substate = recoveryRcvrLock, -> ISSUE.
- linkEnable=0 in any state -> IDLE at the next edge: substate=detectQuiet, linkUp=0. This overrides all other transitions.
- lpifStatus:
  - 0 in IDLE.
  - 2 in LINKUP.
  - 3 when substate is in recoveryRcvrLock..recoveryIdle (including the equalization phases).
  - 1 otherwise.
- failCount saturates at 8'hFF. Only reset clears failCount and exitMismatch.

## Timing
- Reset values:
  - FSM = IDLE.
  - substate = detectQuiet (5'd0).
  - substateReq, linkUp, exitMismatch, lpifStatus, failCount = 0.
  - Internal flags and watchdog = 0.
- All outputs are registered.
- Finish-to-request latency:
  - Last finish at edge N -> RESOLVE in cycle N+1.
  - New substate and substateReq visible in cycle N+2.
- substate changes only on the edge that enters ISSUE or LINKUP. It is stable whenever substateReq=1.
- txFinish/rxFinish arriving in IDLE, ISSUE, RESOLVE or LINKUP are ignored.
- Watchdog expiry in the same cycle as the completing finish: the finish wins and the watchdog is ignored.
- retrainReq in the same cycle as linkEnable falling: IDLE wins.
- An exit value outside 0..18 is treated as detectQuiet.

## Structure
- Shared package `ltssm_pkg`:
  - 5-bit substate encoding: detectQuiet=0 … L0=10, recoveryRcvrLock=11, recoveryRcvrCfg=12, recoverySpeed=13, phase0..3=14..17, recoveryIdle=18.
  - lpifStatus codes.
  - Timer selection codes shared with the TX/RX checkers.
- One natural sub-module: `ltssm_watchdog`, a loadable counter with clear and expire outputs.
- The FSM, exit resolution and status logic stay in the top module.

## Test plan
- Normal training:
  - Stimulus: linkEnable=1; checkers answer each request after 5 cycles with equal exits 1,2,3,…,10.
  - Required: substate steps 0->1->…->10; each substateReq is 2 cycles after the last finish; linkUp=1; lpifStatus=2.
- Skewed finishes:
  - Stimulus: in substate 4, rxFinish at cycle 3 and txFinish at cycle 40, both exit 5.
  - Required: no advance before txFinish; substate=5 two cycles after txFinish.
- Failure path:
  - Stimulus: in substate 3, rxExitTo=0, txExitTo=4.
  - Required: substate=0, failCount=1, exitMismatch=0.
- Mismatch:
  - Stimulus: txExitTo=7, rxExitTo=6 from substate 5.
  - Required: substate=6, exitMismatch=1.
- Watchdog:
  - Stimulus: WDOG_LIMIT=100, txFinish withheld.
  - Required: at cycle 100 of WAIT, substate=0, failCount=1, one substateReq.
- Retrain and abort:
  - Stimulus: in L0, pulse retrainReq.
  - Required: substate=11, lpifStatus=3, linkUp=0.
  - Stimulus: drop linkEnable mid-WAIT.
  - Required: substate=0 and FSM=IDLE next cycle.
  - Stimulus: assert reset mid-WAIT.
  - Required: all outputs return to their reset values.
